// File: rtl/fetch_queue_if.sv
// Sysbus memory-port signals between the fetch queue (master) and the memory side (slave).
interface fetch_queue_if #(
  parameter int TAG_W = 13
);
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches 64-byte lines over Sysbus into a 128-byte
// circular buffer and presents a 15-byte decode window with its RIP.
module fetch_queue #(
  parameter int TAG_W = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   entry,
  fetch_queue_if.master bus,
  input  logic          redirect,
  input  logic [63:0]   redirect_rip,
  output logic          win_valid,
  output logic [119:0]  win_bytes,
  output logic [63:0]   win_rip,
  output logic [7:0]    occupancy,
  input  logic [3:0]    consume,
  output logic [1:0]    dbg_state
);
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [TAG_W-1:0] REQ_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'b0};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RECV = 2'd2} state_t;

  state_t       state_q, state_d;
  logic         reqcyc_q, reqcyc_d;
  logic [63:0]  line_addr_q, line_addr_d;
  logic [63:0]  restart_line_q, restart_line_d;
  logic [2:0]   skip_q, skip_d;
  logic [2:0]   head_skip_q, head_skip_d;
  logic [2:0]   beat_q, beat_d;
  logic         discard_q, discard_d;
  logic [6:0]   wr_ptr_q, wr_ptr_d;
  logic [6:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]   occ_q, occ_d;
  logic [63:0]  win_rip_q, win_rip_d;
  logic         win_valid_q, win_valid_d;
  logic [119:0] win_bytes_q, win_bytes_d;
  logic [7:0]   mem_q [128];
  logic [7:0]   mem_d [128];

  logic         beat_fire, last_beat, keep_beat;
  logic [7:0]   fill_add;

  // Handshake: reqcyc/req are held stable until the cycle reqack is high; every
  // response beat is accepted in the cycle it arrives (respack mirrors respcyc).
  assign bus.reqcyc  = reqcyc_q;
  assign bus.req     = line_addr_q;
  assign bus.reqtag  = REQ_TAG;
  assign bus.respack = bus.respcyc;

  assign win_valid = win_valid_q;
  assign win_bytes = win_bytes_q;
  assign win_rip   = win_rip_q;
  assign occupancy = occ_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d        = state_q;
    reqcyc_d       = reqcyc_q;
    line_addr_d    = line_addr_q;
    restart_line_d = restart_line_q;
    skip_d         = skip_q;
    head_skip_d    = head_skip_q;
    beat_d         = beat_q;
    discard_d      = discard_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    occ_d          = occ_q;
    win_rip_d      = win_rip_q;
    mem_d          = mem_q;
    fill_add       = 8'd0;

    beat_fire = (state_q != S_IDLE) && bus.respcyc;
    last_beat = beat_fire && (beat_q == 3'd7);
    keep_beat = beat_fire && !discard_q && !redirect && (beat_q >= skip_q);

    case (state_q)
      S_IDLE: begin
        if (reqcyc_q) begin
          if (bus.reqack) begin
            reqcyc_d = 1'b0;
            state_d  = S_WAIT;
          end
        end else if (!discard_q && occ_q <= 8'd64) begin
          reqcyc_d = 1'b1;
        end
      end
      default: begin
        if (beat_fire) begin
          state_d = S_RECV;
          beat_d  = beat_q + 3'd1;
          if (last_beat) begin
            state_d = S_IDLE;
            skip_d  = 3'd0;
            if (discard_q) begin
              discard_d   = 1'b0;
              line_addr_d = restart_line_q;
            end else begin
              line_addr_d = line_addr_q + 64'd64;
            end
          end
        end
      end
    endcase

    if (redirect) begin
      rd_ptr_d       = {4'd0, redirect_rip[2:0]};
      wr_ptr_d       = 7'd0;
      occ_d          = 8'd0;
      head_skip_d    = redirect_rip[2:0];
      skip_d         = redirect_rip[5:3];
      win_rip_d      = redirect_rip;
      restart_line_d = {redirect_rip[63:6], 6'd0};
      // A line is still owed on the bus unless this is its final beat.
      if (reqcyc_q || (state_q != S_IDLE && !last_beat)) begin
        discard_d = 1'b1;
      end else begin
        discard_d   = 1'b0;
        line_addr_d = {redirect_rip[63:6], 6'd0};
      end
    end else begin
      if (keep_beat) begin
        for (int j = 0; j < 8; j++) begin
          mem_d[wr_ptr_q + 7'(j)] = bus.resp[8*j +: 8];
        end
        wr_ptr_d    = wr_ptr_q + 7'd8;
        fill_add    = 8'd8 - {5'd0, head_skip_q};
        head_skip_d = 3'd0;
      end
      rd_ptr_d  = rd_ptr_q + {3'd0, consume};
      win_rip_d = win_rip_q + {60'd0, consume};
      occ_d     = occ_q + fill_add - {4'd0, consume};
    end
  end

  always_comb begin
    win_bytes_d = '0;
    for (int i = 0; i < 15; i++) begin
      win_bytes_d[8*i +: 8] = mem_d[rd_ptr_d + 7'(i)];
    end
    win_valid_d = (occ_d >= 8'd15);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      reqcyc_q       <= 1'b0;
      line_addr_q    <= {entry[63:6], 6'd0};
      restart_line_q <= {entry[63:6], 6'd0};
      skip_q         <= entry[5:3];
      head_skip_q    <= entry[2:0];
      beat_q         <= 3'd0;
      discard_q      <= 1'b0;
      wr_ptr_q       <= 7'd0;
      rd_ptr_q       <= {4'd0, entry[2:0]};
      occ_q          <= 8'd0;
      win_rip_q      <= entry;
      win_valid_q    <= 1'b0;
      win_bytes_q    <= '0;
      for (int k = 0; k < 128; k++) mem_q[k] <= 8'd0;
    end else begin
      state_q        <= state_d;
      reqcyc_q       <= reqcyc_d;
      line_addr_q    <= line_addr_d;
      restart_line_q <= restart_line_d;
      skip_q         <= skip_d;
      head_skip_q    <= head_skip_d;
      beat_q         <= beat_d;
      discard_q      <= discard_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      win_rip_q      <= win_rip_d;
      win_valid_q    <= win_valid_d;
      win_bytes_q    <= win_bytes_d;
      for (int k = 0; k < 128; k++) mem_q[k] <= mem_d[k];
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: line fill, skip/head alignment, drain and wrap,
// redirect with discard, and asynchronous reset mid-line.
module tb_fetch_queue;
  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   entry;
  logic          redirect;
  logic [63:0]   redirect_rip;
  logic [3:0]    consume;
  logic          win_valid;
  logic [119:0]  win_bytes;
  logic [63:0]   win_rip;
  logic [7:0]    occupancy;
  logic [1:0]    dbg_state;

  int tests  = 0;
  int failed = 0;

  fetch_queue_if #(.TAG_W(13)) bus ();

  fetch_queue #(.TAG_W(13)) dut (
    .clk          (clk),
    .reset        (reset),
    .entry        (entry),
    .bus          (bus),
    .redirect     (redirect),
    .redirect_rip (redirect_rip),
    .win_valid    (win_valid),
    .win_bytes    (win_bytes),
    .win_rip      (win_rip),
    .occupancy    (occupancy),
    .consume      (consume),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Memory image: each byte holds the low 8 bits of its own address.
  function automatic logic [63:0] beat_model(input logic [63:0] line, input int k);
    logic [63:0] d;
    logic [63:0] a;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      a = line + 64'(8*k + j);
      d[8*j +: 8] = a[7:0];
    end
    return d;
  endfunction

  function automatic logic [119:0] win_model(input logic [63:0] rip);
    logic [119:0] w;
    logic [63:0]  a;
    w = '0;
    for (int i = 0; i < 15; i++) begin
      a = rip + 64'(i);
      w[8*i +: 8] = a[7:0];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [63:0] exp_addr);
    int n;
    n = 0;
    while (!bus.reqcyc && n < 40) begin
      tick();
      n++;
    end
    check("req_seen", 128'(bus.reqcyc), 128'(1'b1));
    check("req_addr", 128'(bus.req), 128'(exp_addr));
    bus.reqack = 1'b1;
    tick();
    bus.reqack = 1'b0;
    check("req_drop", 128'(bus.reqcyc), 128'(1'b0));
  endtask

  task automatic send_beat(input logic [63:0] line, input int k);
    bus.respcyc = 1'b1;
    bus.resp    = beat_model(line, k);
    tick();
    bus.respcyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    entry        = 64'h1000;
    redirect     = 1'b0;
    redirect_rip = '0;
    consume      = 4'd0;
    bus.reqack   = 1'b0;
    bus.respcyc  = 1'b0;
    bus.resp     = '0;

    // Reset state
    repeat (3) tick();
    check("rst_reqcyc", 128'(bus.reqcyc), 128'(1'b0));
    check("rst_req", 128'(bus.req), 128'(64'h1000));
    check("rst_reqtag", 128'(bus.reqtag), 128'(13'h1100));
    check("rst_win_valid", 128'(win_valid), 128'(1'b0));
    check("rst_occ", 128'(occupancy), 128'(8'd0));
    check("rst_win_rip", 128'(win_rip), 128'(64'h1000));
    check("rst_win_bytes", 128'(win_bytes), 128'(120'd0));
    check("rst_state", 128'(dbg_state), 128'(2'd0));

    // First request one edge after release
    reset = 1'b1;
    tick();
    check("first_reqcyc", 128'(bus.reqcyc), 128'(1'b1));
    wait_req(64'h1000);
    check("state_wait", 128'(dbg_state), 128'(2'd1));

    send_beat(64'h1000, 0);
    check("l0_b0_valid", 128'(win_valid), 128'(1'b0));
    check("l0_b0_occ", 128'(occupancy), 128'(8'd8));
    send_beat(64'h1000, 1);
    check("l0_b1_valid", 128'(win_valid), 128'(1'b1));
    check("l0_b1_byte0", 128'(win_bytes[7:0]), 128'(8'h00));
    check("l0_b1_win", 128'(win_bytes), 128'(win_model(64'h1000)));
    for (int k = 2; k < 8; k++) send_beat(64'h1000, k);
    check("l0_occ", 128'(occupancy), 128'(8'd64));

    // Occupancy 64 still qualifies for the next line; buffer reaches full
    wait_req(64'h1040);
    for (int k = 0; k < 8; k++) send_beat(64'h1040, k);
    check("full_occ", 128'(occupancy), 128'(8'd128));
    check("full_valid", 128'(win_valid), 128'(1'b1));
    tick();
    check("full_no_req", 128'(bus.reqcyc), 128'(1'b0));

    // Drain 75 bytes at full rate
    for (int c = 0; c < 5; c++) begin
      consume = 4'd15;
      tick();
    end
    consume = 4'd0;
    check("drain_occ", 128'(occupancy), 128'(8'd53));
    check("drain_rip", 128'(win_rip), 128'(64'h104B));
    check("drain_win", 128'(win_bytes), 128'(win_model(64'h104B)));

    // Fill with concurrent consume; window then wraps across byte 127/0
    wait_req(64'h1080);
    consume = 4'd15;
    send_beat(64'h1080, 0);
    check("fill_drain_occ", 128'(occupancy), 128'(8'd46));
    send_beat(64'h1080, 1);
    send_beat(64'h1080, 2);
    consume = 4'd0;
    for (int k = 3; k < 8; k++) send_beat(64'h1080, k);
    check("wrap_occ", 128'(occupancy), 128'(8'd72));
    check("wrap_rip", 128'(win_rip), 128'(64'h1078));
    check("wrap_win", 128'(win_bytes), 128'(win_model(64'h1078)));

    // Redirect during beat 3 of a line
    consume = 4'd15;
    tick();
    consume = 4'd0;
    check("pre_redir_occ", 128'(occupancy), 128'(8'd57));
    wait_req(64'h10C0);
    for (int k = 0; k < 3; k++) send_beat(64'h10C0, k);
    check("pre_redir_occ2", 128'(occupancy), 128'(8'd81));
    bus.respcyc  = 1'b1;
    bus.resp     = beat_model(64'h10C0, 3);
    redirect     = 1'b1;
    redirect_rip = 64'h2000;
    #1;
    check("respack_comb", 128'(bus.respack), 128'(1'b1));
    tick();
    redirect    = 1'b0;
    bus.respcyc = 1'b0;
    check("redir_occ", 128'(occupancy), 128'(8'd0));
    check("redir_rip", 128'(win_rip), 128'(64'h2000));
    check("redir_valid", 128'(win_valid), 128'(1'b0));
    for (int k = 4; k < 7; k++) send_beat(64'h10C0, k);
    check("discard_no_req", 128'(bus.reqcyc), 128'(1'b0));
    check("discard_occ", 128'(occupancy), 128'(8'd0));
    send_beat(64'h10C0, 7);
    check("discard_end_no_req", 128'(bus.reqcyc), 128'(1'b0));
    wait_req(64'h2000);

    // Redirect, beat and consume in the same cycle
    send_beat(64'h2000, 0);
    send_beat(64'h2000, 1);
    check("l2000_occ", 128'(occupancy), 128'(8'd16));
    check("l2000_win", 128'(win_bytes), 128'(win_model(64'h2000)));
    bus.respcyc  = 1'b1;
    bus.resp     = beat_model(64'h2000, 2);
    redirect     = 1'b1;
    redirect_rip = 64'h3005;
    consume      = 4'd4;
    tick();
    bus.respcyc  = 1'b0;
    redirect     = 1'b0;
    consume      = 4'd0;
    check("same_cyc_occ", 128'(occupancy), 128'(8'd0));
    check("same_cyc_rip", 128'(win_rip), 128'(64'h3005));
    for (int k = 3; k < 8; k++) send_beat(64'h2000, k);
    wait_req(64'h3000);
    send_beat(64'h3000, 0);
    check("head_skip_occ", 128'(occupancy), 128'(8'd3));
    send_beat(64'h3000, 1);
    check("head_skip_valid_lo", 128'(win_valid), 128'(1'b0));
    send_beat(64'h3000, 2);
    check("head_skip_occ2", 128'(occupancy), 128'(8'd19));
    check("head_skip_valid", 128'(win_valid), 128'(1'b1));
    check("head_skip_win", 128'(win_bytes), 128'(win_model(64'h3005)));
    send_beat(64'h3000, 3);

    // Asynchronous reset mid-line, refetch from new entry
    #3;
    entry = 64'h4010;
    reset = 1'b0;
    #1;
    check("async_occ", 128'(occupancy), 128'(8'd0));
    check("async_reqcyc", 128'(bus.reqcyc), 128'(1'b0));
    check("async_req", 128'(bus.req), 128'(64'h4000));
    check("async_rip", 128'(win_rip), 128'(64'h4010));
    check("async_valid", 128'(win_valid), 128'(1'b0));
    check("async_state", 128'(dbg_state), 128'(2'd0));
    reset = 1'b1;
    tick();
    check("rerel_reqcyc", 128'(bus.reqcyc), 128'(1'b1));
    wait_req(64'h4000);
    send_beat(64'h4000, 0);
    send_beat(64'h4000, 1);
    check("skip2_occ", 128'(occupancy), 128'(8'd0));
    send_beat(64'h4000, 2);
    check("skip2_occ2", 128'(occupancy), 128'(8'd8));
    check("skip2_byte0", 128'(win_bytes[7:0]), 128'(8'h10));
    check("skip2_rip", 128'(win_rip), 128'(64'h4010));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
